// File: rtl/imem_fetch_if.sv
// imem_fetch_if: fetch request/response and program-load signals of the instruction memory
interface imem_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_inst;
    logic [ADDR_W-1:0] rsp_addr;
    logic [1:0]        rsp_err;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    modport master (
        output req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
    );
    modport slave (
        input  req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
        output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
    );
endinterface

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: instruction memory with valid/ready fetch, fixed read latency and in-order response FIFO
module imem_fetch_port #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4096,
    parameter int LATENCY   = 1,
    parameter int BUF_DEPTH = 2
) (
    input logic         clk,
    input logic         rst_n,
    imem_fetch_if.slave bus
);
    localparam int EW = 1 + ADDR_W + 2 + DATA_W;
    localparam int MW = $clog2(DEPTH);
    localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + LATENCY + 1);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [EW-2:0]     fifo_d [BUF_DEPTH];
    logic              acc, push, pop;
    logic [1:0]        err;
    logic [EW-1:0]     ent_in, push_ent;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     cnt, inflight;
    logic [MW-1:0]     ridx, widx;
    assign ridx   = bus.req_addr[MW+1:2];
    assign widx   = bus.prog_addr[MW+1:2];
    assign acc    = bus.req_valid && bus.req_ready;
    assign err    = |bus.req_addr[1:0] ? 2'b01 : (bus.req_addr >> 2) >= ADDR_W'(DEPTH) ? 2'b10 : 2'b00;
    assign ent_in = {acc, bus.req_addr, err, err == 2'b00 ? mem[ridx] : DATA_W'(0)};
    always_ff @(posedge clk)
        if (bus.prog_we && bus.prog_addr[1:0] == 2'b00 && (bus.prog_addr >> 2) < ADDR_W'(DEPTH))
            mem[widx] <= bus.prog_data;
    // Entry carries its valid bit at the MSB through the latency pipeline
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_ent = ent_in;
            assign inflight = '0;
        end else begin : g_pipe
            logic [EW-1:0] q [LATENCY-1];
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    for (int j = 0; j < LATENCY - 1; j++) q[j] <= '0;
                end else begin
                    q[0] <= ent_in;
                    for (int j = 1; j < LATENCY - 1; j++) q[j] <= q[j-1];
                end
            always_comb begin
                inflight = '0;
                for (int j = 0; j < LATENCY - 1; j++) inflight = inflight + CW'(q[j][EW-1]);
            end
            assign push_ent = q[LATENCY-2];
        end
    endgenerate
    assign push          = push_ent[EW-1];
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign bus.rsp_valid = cnt != '0;
    assign bus.req_ready = rst_n && !bus.prog_we && (inflight + cnt < CW'(BUF_DEPTH));
    assign {bus.rsp_addr, bus.rsp_err, bus.rsp_inst} = bus.rsp_valid ? fifo_d[rd_ptr] : '0;
    always_ff @(posedge clk)
        if (push) fifo_d[wr_ptr] <= push_ent[EW-2:0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == PW'(BUF_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == PW'(BUF_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    // Credit accounting must make a push into a full FIFO impossible
    assert property (@(posedge clk) disable iff (!rst_n) !(push && cnt == CW'(BUF_DEPTH)));
endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
- Parametrised, clocked instruction memory with a valid/ready fetch handshake, a configurable read latency and an in-order response buffer.
- Replaces the combinational, hard-coded instruction ROM of the single-cycle CPU, so the core can later move to a pipelined fetch.
- A program-load write port fills the memory at boot. Misaligned and out-of-range fetches return an error code instead of a floating bus.

Parameters:
- ADDR_W, 32, byte-address width of req_addr, rsp_addr and prog_addr.
- DATA_W, 32, instruction word width.
- DEPTH, 4096, number of words stored. The word index is addr[ADDR_W-1:2].
- LATENCY, 1, request-accept to response-visible latency in cycles. Legal range 1..4.
- BUF_DEPTH, 2, response FIFO depth. Must be >= LATENCY+1 for full throughput.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request can be accepted.
- req_addr  in  ADDR_W  fetch byte address.
- rsp_valid  out  1  response at FIFO head is valid.
- rsp_ready  in  1  consumer takes the head response.
- rsp_inst  out  DATA_W  fetched instruction. Zero when rsp_err != 0.
- rsp_addr  out  ADDR_W  byte address of the request that produced this response.
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range.
- prog_we  in  1  program-load write enable.
- prog_addr  in  ADDR_W  program-load byte address.
- prog_data  in  DATA_W  program-load word.

Behaviour:
- Reset (async assert, rst_n low):
  - Pipeline valid bits and FIFO pointers/count clear immediately.
  - rsp_valid=0, rsp_inst=0, rsp_addr=0, rsp_err=0.
  - req_ready is forced 0 while rst_n=0.
  - Memory contents are not cleared. Reset mid-operation discards all in-flight and buffered responses.
  - Deassertion is synchronised by the environment. The first acceptance is possible on the first rising edge after release.
- Program load:
  - On a rising edge with prog_we=1, mem[prog_addr>>2] <= prog_data.
  - The write is dropped if prog_addr[1:0]!=0 or the word index >= DEPTH.
  - req_ready=0 in any cycle with prog_we=1, so reads and writes never collide.
- Request acceptance:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - req_ready = rst_n && !prog_we && (inflight + fifo_count < BUF_DEPTH). A same-cycle pop is not credited.
  - req_addr is only sampled on acceptance. The consumer may hold or change it freely otherwise.
- Error classification, at acceptance:
  - addr[1:0]!=0 gives err=01. This takes priority over range.
  - Otherwise, word index >= DEPTH gives err=10.
  - Otherwise err=00 and the memory word is read.
  - Data read on error is 0.
- Read timing:
  - The memory word is sampled at the acceptance edge. A later program write does not alter it.
  - The entry passes through LATENCY-1 pipeline registers (none for LATENCY=1) and is pushed into the FIFO.
  - With an empty FIFO, a request accepted at edge k shows rsp_valid=1 in the cycle following edge k+LATENCY-1.
  - Example: LATENCY=1 gives a response in the cycle right after acceptance.
- Response FIFO:
  - In-order, BUF_DEPTH entries.
  - rsp_* are driven from the head register, not combinationally from req_*.
  - Pop on a rising edge with rsp_valid && rsp_ready. Push and pop may occur on the same edge; the count is unchanged and order is preserved.
  - The credit rule guarantees a push never finds the FIFO full. An assertion checks this.
  - Pointers wrap modulo BUF_DEPTH.
- Back-pressure:
  - rsp_ready=0 holds rsp_* stable while rsp_valid=1.
  - Requests stall once outstanding = BUF_DEPTH.
- Throughput: one fetch per cycle when rsp_ready=1 and BUF_DEPTH >= LATENCY+1.

Test Plan:
1. Load mem[0x4]=0x00123237 and mem[0x8]=0x0000F193. Fetch 0x4 then 0x8 back-to-back, rsp_ready=1, LATENCY=1 -> responses in consecutive cycles: {0x4,0x00123237,00} then {0x8,0x0000F193,00}, with req_ready staying 1.
2. Fetch 0x33 -> rsp_inst=0, rsp_err=01, rsp_addr=0x33. Fetch 0x4000 with DEPTH=4096 -> rsp_err=10. Fetch 0x4001 -> rsp_err=01 (misaligned wins).
3. rsp_ready=0, issue fetches 0x4, 0x8, 0xC -> first two accepted, req_ready=0 from the cycle after the second acceptance. Raise rsp_ready -> 0xC is accepted after a pop; order is 0x4, 0x8, 0xC.
4. LATENCY=3, BUF_DEPTH=4, streaming fetches -> first rsp_valid in the 3rd cycle after acceptance, then 1/cycle with no bubbles.
5. Accept fetch 0x10, then hold prog_we=1 writing 0xDEADBEEF to 0x10 -> response returns the old word, and req_ready=0 during the write. A subsequent fetch of 0x10 returns 0xDEADBEEF.
6. Assert rst_n=0 mid-edge with 2 responses buffered -> rsp_valid=0 immediately, no stale responses after release, memory word at 0x4 still intact on refetch.
